// File: rtl/ntt_collect_pkg.sv
// Types and constants shared by the NTT output collector and its bench.
`include "ntt_param.svh"

package ntt_collect_pkg;

   localparam int unsigned DataWidth = `DATA_WIDTH;
   localparam int unsigned PolyLen   = `NTT_N;
   localparam int unsigned Beats     = `NTT_BEATS;

   typedef logic [1:0] state_t;

   localparam state_t StIdle  = 2'd0;
   localparam state_t StFill  = 2'd1;
   localparam state_t StDrain = 2'd2;

endpackage

// File: rtl/coef_bank.sv
// One half of the collector buffer: simple dual-port RAM with a registered, enabled read.
module coef_bank #(
   parameter int unsigned Depth = 128,
   parameter int unsigned Width = 16
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(Depth)-1:0] waddr_i,
   input  logic [Width-1:0]         wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(Depth)-1:0] raddr_i,
   output logic [Width-1:0]         rdata_o
);

   logic [Width-1:0] mem [Depth];

   // No reset: contents are always rewritten before they are read.
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
   end

endmodule

// File: rtl/ntt_param.svh
// Shared NTT sizing: coefficient width, polynomial length and the derived beat count.
`ifndef NTT_PARAM_SVH
`define NTT_PARAM_SVH
`define DATA_WIDTH 16
`define NTT_N 256
`define NTT_BEATS (`NTT_N / 2)
`endif

// File: rtl/ntt_collect.sv
// Collects NTT butterfly output pairs (k, k+N/2) into two banks, then streams the
// polynomial out in natural order over a valid/ready interface.
`include "ntt_param.svh"

module ntt_collect
   import ntt_collect_pkg::*;
#(
   parameter int unsigned N = `NTT_N,
   parameter int unsigned W = `DATA_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_en,
   input  logic [W-1:0]         in1,
   input  logic [W-1:0]         in2,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [W-1:0]         out_data,
   output logic [$clog2(N)-1:0] out_idx,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 overflow
);

   localparam int unsigned Half = N / 2;
   localparam int unsigned IW   = $clog2(N);
   localparam int unsigned AW   = $clog2(Half);

   state_t         state_q, state_d;
   logic [AW-1:0]  wr_cnt_q, wr_cnt_d;
   logic [IW:0]    rd_cnt_q, rd_cnt_d;
   logic           out_valid_q, out_valid_d;
   logic [IW-1:0]  out_idx_q, out_idx_d;
   logic           done_q, done_d;
   logic           ovf_q, ovf_d;

   logic           wr_fire, wr_last, rd_more, rd_adv, last_hs;
   logic [W-1:0]   lo_rdata, up_rdata;

   assign wr_fire  = in_en && !flush && (state_q != StDrain);
   assign wr_last  = (wr_cnt_q == AW'(Half - 1));
   assign rd_more  = (rd_cnt_q != (IW + 1)'(N));
   // Advance the read pipeline whenever the output slot is empty or being consumed.
   assign rd_adv   = (state_q == StDrain) && rd_more && (!out_valid_q || out_ready);
   assign out_last = out_valid_q && (out_idx_q == IW'(N - 1));
   assign last_hs  = out_valid_q && out_ready && out_last;

   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      out_valid_d = out_valid_q;
      out_idx_d   = out_idx_q;
      ovf_d       = ovf_q;
      done_d      = 1'b0;
      if (flush) begin
         state_d     = StIdle;
         wr_cnt_d    = '0;
         rd_cnt_d    = '0;
         out_valid_d = 1'b0;
         out_idx_d   = '0;
         ovf_d       = 1'b0;
      end else begin
         case (state_q)
            StIdle, StFill: begin
               if (in_en) begin
                  if (wr_last) begin
                     state_d  = StDrain;
                     wr_cnt_d = '0;
                     rd_cnt_d = '0;
                  end else begin
                     state_d  = StFill;
                     wr_cnt_d = wr_cnt_q + 1'b1;
                  end
               end
            end
            StDrain: begin
               if (in_en) ovf_d = 1'b1;
               if (rd_adv) begin
                  rd_cnt_d    = rd_cnt_q + 1'b1;
                  out_valid_d = 1'b1;
                  out_idx_d   = rd_cnt_q[IW-1:0];
               end
               if (last_hs) begin
                  state_d     = StIdle;
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         wr_cnt_q    <= '0;
         rd_cnt_q    <= '0;
         out_valid_q <= 1'b0;
         out_idx_q   <= '0;
         done_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_cnt_q    <= wr_cnt_d;
         rd_cnt_q    <= rd_cnt_d;
         out_valid_q <= out_valid_d;
         out_idx_q   <= out_idx_d;
         done_q      <= done_d;
         ovf_q       <= ovf_d;
      end
   end

   coef_bank #(
      .Depth (Half),
      .Width (W)
   ) u_bank_lo (
      .clk_i   (clk),
      .we_i    (wr_fire),
      .waddr_i (wr_cnt_q),
      .wdata_i (in1),
      .re_i    (rd_adv && !rd_cnt_q[IW-1]),
      .raddr_i (rd_cnt_q[AW-1:0]),
      .rdata_o (lo_rdata)
   );

   coef_bank #(
      .Depth (Half),
      .Width (W)
   ) u_bank_up (
      .clk_i   (clk),
      .we_i    (wr_fire),
      .waddr_i (wr_cnt_q),
      .wdata_i (in2),
      .re_i    (rd_adv && rd_cnt_q[IW-1]),
      .raddr_i (rd_cnt_q[AW-1:0]),
      .rdata_o (up_rdata)
   );

   // Bank read data holds while stalled, so gating by valid keeps outputs stable and zero in reset.
   assign out_data  = out_valid_q ? (out_idx_q[IW-1] ? up_rdata : lo_rdata) : '0;
   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign overflow  = ovf_q;

endmodule

// File: doc/ntt_collect.md
NTT_COLLECT -- requirements
Module: ntt_collect

Interface
REQ-001 SHALL have parameter N, default 256, meaning polynomial length; N/2 input beats per polynomial.
REQ-002 SHALL have parameter W, default `DATA_WIDTH, meaning coefficient width.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning asynchronous active-high reset.
REQ-005 SHALL have port in_en, input, 1, meaning the NTT output pair is valid this cycle.
REQ-006 SHALL have port in1, input, W, meaning coefficient k of beat k.
REQ-007 SHALL have port in2, input, W, meaning coefficient k+N/2 of beat k.
REQ-008 SHALL have port flush, input, 1, meaning synchronous abort to IDLE.
REQ-009 SHALL have port out_valid, output, 1, meaning out_data/out_idx are valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer accepts the current word.
REQ-011 SHALL have port out_data, output, W, meaning coefficient in natural order.
REQ-012 SHALL have port out_idx, output, $clog2(N), meaning index of out_data.
REQ-013 SHALL have port out_last, output, 1, meaning out_idx == N-1 while out_valid.
REQ-014 SHALL have port busy, output, 1, meaning state is not IDLE.
REQ-015 SHALL have port done, output, 1, meaning a one-cycle pulse after the last word handshake.
REQ-016 SHALL have port overflow, output, 1, meaning sticky: an in_en beat was dropped.

Function
REQ-017 SHALL implement the states IDLE, FILL and DRAIN.
REQ-018 SHALL move from IDLE to FILL on the first in_en, and SHALL store that beat as beat 0.
REQ-019 SHALL, for each in_en in IDLE or FILL, write in1 to lower-bank address k and in2 to upper-bank address k, then increment k.
REQ-020 SHALL accept gaps in in_en; the beat counter holds while in_en is low.
REQ-021 SHALL enter DRAIN at the edge that captures beat N/2-1 and reset k to 0.
REQ-022 SHALL raise out_valid one edge after entering DRAIN, with out_idx = 0 (one-cycle bank read latency).
REQ-023 SHALL perform a read as out_valid && out_ready.
REQ-024 SHALL, while out_valid && !out_ready, hold out_data, out_idx and out_last stable.
REQ-025 SHALL, with out_ready held high, sustain one word per cycle, giving index 255 at the 256th cycle after entering DRAIN.
REQ-026 SHALL select the bank by out_idx MSB (0 = lower bank) and the address by out_idx[MSB-1:0].
REQ-027 SHALL, on the handshake with out_last, drop out_valid, go to IDLE and pulse done for the following cycle.
REQ-028 SHALL drop any in_en during DRAIN without writing it, and SHALL set overflow.
REQ-029 SHALL clear overflow only on rst or flush.
REQ-030 SHALL, on flush in any state, go to IDLE at the next edge, clear counters, out_valid and overflow, and leave done low.
REQ-031 SHALL give flush priority over a coincident in_en, dropping that beat without setting overflow.
REQ-032 SHALL give the out_last handshake priority over a coincident in_en: the FSM goes to IDLE, and that in_en is dropped and sets overflow.

Reset
REQ-033 SHALL, while rst is high, force state IDLE, beat counter and read counter 0, out_valid, out_last, done, overflow and busy 0, and out_data and out_idx 0.
REQ-034 SHALL, on rst asserted mid-FILL or mid-DRAIN, abandon the partial polynomial; bank contents are not reset and are not read before refill.
REQ-035 SHALL, after rst deasserts, treat the first in_en as beat 0.

Structure
REQ-036 SHALL take DATA_WIDTH and the polynomial length from ntt_param.svh, and SHALL add the derived beat count there.
REQ-037 SHALL implement each bank as one sub-module coef_bank (N/2 x W, one synchronous write port, one synchronous read port, registered read, read-enable), instantiated twice.
REQ-038 SHALL keep the FSM, counters and output register in ntt_collect.

Verification
REQ-039 SHALL cover back-to-back fill: 128 contiguous beats with in1 = k and in2 = k+128, out_ready = 1 -> out_data = 0..255 in order, one per cycle, out_last at 255, done one cycle later.
REQ-040 SHALL cover gapped fill and backpressure: in_en every third cycle, out_ready toggling 1/0 -> identical sequence, with data held stable on every stalled cycle.
REQ-041 SHALL cover overflow: 3 extra beats during DRAIN -> overflow = 1 and output sequence unchanged.
REQ-042 SHALL cover a flush mid-FILL: flush after beat 60, then a fresh 128 beats of value 7 -> 256 words of 7 and overflow = 0.
REQ-043 SHALL cover reset mid-DRAIN: rst pulse at out_idx 100 -> all outputs 0 immediately, then a clean refill drains correctly.
REQ-044 SHALL cover the last-handshake race: in_en coincident with the out_last handshake -> state IDLE and overflow = 1.
